game_sequencer: RTL and testbench

Central phase controller for the snake game. It replaces ad-hoc gating of the tick generator with an explicit state machine. It counts VGA frames to schedule snake moves and issues a single-cycle move request to the snake datapath. It waits for the snake's move-done handshake and for apple re-placement, and it tracks pause, score, speed-up and terminal win/lose states. It sits between control/vga (start, pause, vsync) and snake/apple/sound (tick, tick_done, eat, ready, failure, success).

---
 rtl/game_sequencer.sv | 161 ++++++++++++++++
 tb/tb_game_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Phase controller for the snake game: paces moves from VGA frames, handshakes
// with the snake and apple logic, and tracks pause, score, speed-up and game end.
module game_sequencer #(
  parameter int TICK_FRAMES_MAX = 15,
  parameter int TICK_FRAMES_MIN = 3,
  parameter int SPEEDUP_EVERY   = 4,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_restart,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_vsync_pulse,
  input  logic       i_tick_done,
  input  logic       i_eat,
  input  logic       i_apple_ready,
  input  logic       i_failure,
  input  logic       i_success,
  output logic       o_tick,
  output logic [2:0] o_state,
  output logic       o_running,
  output logic [3:0] o_frames_per_tick,
  output logic [7:0] o_score,
  output logic       o_error
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN_WAIT = 3'd1;
  localparam logic [2:0] ST_MOVE     = 3'd2;
  localparam logic [2:0] ST_PLACE    = 3'd3;
  localparam logic [2:0] ST_PAUSED   = 3'd4;
  localparam logic [2:0] ST_LOST     = 3'd5;
  localparam logic [2:0] ST_WON      = 3'd6;

  localparam logic [3:0] FPT_MAX         = 4'(TICK_FRAMES_MAX);
  localparam logic [3:0] FPT_MIN         = 4'(TICK_FRAMES_MIN);
  localparam logic [3:0] APPLES_PER_STEP = 4'(SPEEDUP_EVERY);
  localparam logic [7:0] WD_LAST         = 8'(WATCHDOG_CYCLES - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] frame_cnt_reg, frame_cnt_next;
  logic [3:0] apple_cnt_reg, apple_cnt_next;
  logic [3:0] fpt_reg, fpt_next;
  logic [7:0] wd_cnt_reg, wd_cnt_next;
  logic [7:0] score_reg, score_next;
  logic       eat_latch_reg, eat_latch_next;
  logic       tick_reg, tick_next;
  logic       error_reg, error_next;

  logic [3:0] frame_inc;
  logic [3:0] apple_inc;
  logic       eaten;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    apple_cnt_next = apple_cnt_reg;
    fpt_next       = fpt_reg;
    wd_cnt_next    = wd_cnt_reg;
    score_next     = score_reg;
    eat_latch_next = eat_latch_reg;
    tick_next      = 1'b0;
    error_next     = error_reg;

    // Including this cycle's vsync lets the tick fire the cycle after the last frame.
    frame_inc = (i_vsync_pulse && (frame_cnt_reg < fpt_reg)) ? frame_cnt_reg + 4'd1
                                                              : frame_cnt_reg;
    apple_inc = apple_cnt_reg + 4'd1;
    eaten     = eat_latch_reg | i_eat;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next     = ST_RUN_WAIT;
          frame_cnt_next = 4'd0;
        end
      end
      ST_RUN_WAIT: begin
        if (i_pause) begin
          state_next = ST_PAUSED;
        end else if ((frame_inc >= fpt_reg) && i_apple_ready) begin
          state_next     = ST_MOVE;
          tick_next      = 1'b1;
          frame_cnt_next = 4'd0;
          wd_cnt_next    = 8'd0;
          eat_latch_next = 1'b0;
        end else begin
          frame_cnt_next = frame_inc;
        end
      end
      ST_PAUSED: begin
        if (!i_pause) state_next = ST_RUN_WAIT;
      end
      ST_MOVE: begin
        eat_latch_next = eaten;
        if (i_tick_done) begin
          eat_latch_next = 1'b0;
          if (i_failure)      state_next = ST_LOST;
          else if (i_success) state_next = ST_WON;
          else if (eaten)     state_next = ST_PLACE;
          else                state_next = ST_RUN_WAIT;
          if (eaten) begin
            if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
            if (apple_inc == APPLES_PER_STEP) begin
              apple_cnt_next = 4'd0;
              if (fpt_reg > FPT_MIN) fpt_next = fpt_reg - 4'd1;
            end else begin
              apple_cnt_next = apple_inc;
            end
          end
        end else if (wd_cnt_reg == WD_LAST) begin
          error_next = 1'b1;
          state_next = ST_LOST;
        end else begin
          wd_cnt_next = wd_cnt_reg + 8'd1;
        end
      end
      ST_PLACE: begin
        if (i_apple_ready) state_next = ST_RUN_WAIT;
      end
      ST_LOST, ST_WON: begin
        state_next = state_reg;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_restart) begin
      state_reg     <= ST_IDLE;
      frame_cnt_reg <= 4'd0;
      apple_cnt_reg <= 4'd0;
      fpt_reg       <= FPT_MAX;
      wd_cnt_reg    <= 8'd0;
      score_reg     <= 8'd0;
      eat_latch_reg <= 1'b0;
      tick_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      apple_cnt_reg <= apple_cnt_next;
      fpt_reg       <= fpt_next;
      wd_cnt_reg    <= wd_cnt_next;
      score_reg     <= score_next;
      eat_latch_reg <= eat_latch_next;
      tick_reg      <= tick_next;
      error_reg     <= error_next;
    end
  end

  assign o_tick            = tick_reg;
  assign o_state           = state_reg;
  assign o_running         = (state_reg == ST_RUN_WAIT) || (state_reg == ST_MOVE) ||
                             (state_reg == ST_PLACE);
  assign o_frames_per_tick = fpt_reg;
  assign o_score           = score_reg;
  assign o_error           = error_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: tick pacing, eating and speed-up, pause,
// end-of-game priority, watchdog and late apple placement.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_restart = 1'b0;
  logic       i_start = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_vsync_pulse = 1'b0;
  logic       i_tick_done = 1'b0;
  logic       i_eat = 1'b0;
  logic       i_apple_ready = 1'b0;
  logic       i_failure = 1'b0;
  logic       i_success = 1'b0;
  logic       o_tick;
  logic [2:0] o_state;
  logic       o_running;
  logic [3:0] o_frames_per_tick;
  logic [7:0] o_score;
  logic       o_error;

  int n_cmp = 0;
  int n_err = 0;
  int n_move = 0;

  game_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_restart         (i_restart),
    .i_start           (i_start),
    .i_pause           (i_pause),
    .i_vsync_pulse     (i_vsync_pulse),
    .i_tick_done       (i_tick_done),
    .i_eat             (i_eat),
    .i_apple_ready     (i_apple_ready),
    .i_failure         (i_failure),
    .i_success         (i_success),
    .o_tick            (o_tick),
    .o_state           (o_state),
    .o_running         (o_running),
    .o_frames_per_tick (o_frames_per_tick),
    .o_score           (o_score),
    .o_error           (o_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    i_vsync_pulse = 1'b1;
    step();
    i_vsync_pulse = 1'b0;
  endtask

  // Send vsyncs (gap idle cycles before each) until o_tick; used = vsyncs sent or -1.
  task automatic wait_tick(input int max_vs, output int used);
    used = -1;
    for (int v = 1; v <= max_vs; v++) begin
      repeat (19) step();
      pulse_vsync();
      if (o_tick) begin
        used = v;
        check_eq("tick_state_move", o_state, 2);
        break;
      end
    end
  endtask

  // Vsyncs that must not cause a tick; returns how many ticks were seen.
  task automatic quiet_vsyncs(input int n, input int gap, output int ticks);
    ticks = 0;
    for (int v = 0; v < n; v++) begin
      repeat (gap) step();
      pulse_vsync();
      if (o_tick) ticks++;
    end
  endtask

  // Done handshake 3 cycles after the tick; eating also drops apple_ready.
  task automatic finish_move(input bit eat, input bit fail, input bit succ);
    step();
    check_eq("tick_one_cycle", o_tick, 0);
    step();
    i_tick_done = 1'b1;
    i_eat       = eat;
    i_failure   = fail;
    i_success   = succ;
    if (eat) i_apple_ready = 1'b0;
    step();
    i_tick_done = 1'b0;
    i_eat       = 1'b0;
    i_failure   = 1'b0;
    i_success   = 1'b0;
    n_move++;
    $display("move %0d: eat=%0d fail=%0d succ=%0d -> state=%0d score=%0d fpt=%0d",
             n_move, eat, fail, succ, o_state, o_score, o_frames_per_tick);
  endtask

  // PLACE holds while apple_ready is low, then leaves the cycle after it rises.
  task automatic place_apple();
    check_eq("place_entry", o_state, 3);
    repeat (9) step();
    check_eq("place_hold", o_state, 3);
    i_apple_ready = 1'b1;
    step();
    check_eq("place_exit", o_state, 1);
  endtask

  task automatic restart_game();
    i_start   = 1'b0;
    i_pause   = 1'b0;
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check_eq("restart_state", o_state, 0);
    check_eq("restart_score", o_score, 0);
    check_eq("restart_fpt", o_frames_per_tick, 15);
    check_eq("restart_error", o_error, 0);
  endtask

  task automatic start_game();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_eq("start_run_wait", o_state, 1);
  endtask

  initial begin
    int used;
    int ticks;
    int exp_fpt;
    int eats;

    // Reset state
    repeat (3) step();
    check_eq("reset_state", o_state, 0);
    check_eq("reset_tick", o_tick, 0);
    check_eq("reset_score", o_score, 0);
    check_eq("reset_error", o_error, 0);
    check_eq("reset_fpt", o_frames_per_tick, 15);
    check_eq("reset_running", o_running, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_holds", o_state, 0);

    // Steady ticks: 15 vsyncs apart, state 0,1,2,1
    i_apple_ready = 1'b1;
    start_game();
    check_eq("running_in_run_wait", o_running, 1);
    for (int k = 0; k < 2; k++) begin
      wait_tick(20, used);
      check_eq("steady_period", used, 15);
      finish_move(1'b0, 1'b0, 1'b0);
      check_eq("steady_back_run_wait", o_state, 1);
      check_eq("steady_score", o_score, 0);
    end

    // Eating: speed-up every 4 apples, saturating at 3 frames
    eats = 0;
    exp_fpt = 15;
    for (int k = 0; k < 52; k++) begin
      wait_tick(20, used);
      check_eq("eat_period", used, exp_fpt);
      finish_move(1'b1, 1'b0, 1'b0);
      eats++;
      if ((eats % 4 == 0) && (exp_fpt > 3)) exp_fpt--;
      check_eq("eat_score", o_score, eats);
      check_eq("eat_fpt", o_frames_per_tick, exp_fpt);
      place_apple();
    end
    check_eq("fpt_saturated", o_frames_per_tick, 3);
    check_eq("score_after_52", o_score, 52);

    // Pause at frame count 7 for 100 vsyncs
    restart_game();
    start_game();
    quiet_vsyncs(7, 19, ticks);
    check_eq("pre_pause_no_tick", ticks, 0);
    step();
    i_pause = 1'b1;
    step();
    check_eq("paused_state", o_state, 4);
    check_eq("paused_not_running", o_running, 0);
    quiet_vsyncs(100, 3, ticks);
    check_eq("paused_no_tick", ticks, 0);
    check_eq("paused_still", o_state, 4);
    i_pause = 1'b0;
    step();
    check_eq("unpause_state", o_state, 1);
    wait_tick(20, used);
    check_eq("resume_period", used, 8);
    finish_move(1'b0, 1'b0, 1'b0);

    // Pause beats a tick completing in the same cycle
    quiet_vsyncs(14, 19, ticks);
    check_eq("pre_prio_no_tick", ticks, 0);
    i_pause = 1'b1;
    pulse_vsync();
    check_eq("pause_prio_tick", o_tick, 0);
    check_eq("pause_prio_state", o_state, 4);
    i_pause = 1'b0;
    step();
    check_eq("pause_prio_release", o_state, 1);

    // Apple not ready when the frame count completes
    restart_game();
    start_game();
    quiet_vsyncs(14, 19, ticks);
    check_eq("pre_late_no_tick", ticks, 0);
    i_apple_ready = 1'b0;
    pulse_vsync();
    check_eq("late_apple_no_tick", o_tick, 0);
    check_eq("late_apple_wait", o_state, 1);
    repeat (49) step();
    check_eq("late_apple_still_wait", o_state, 1);
    i_apple_ready = 1'b1;
    step();
    check_eq("late_apple_tick", o_tick, 1);
    check_eq("late_apple_move", o_state, 2);
    finish_move(1'b0, 1'b0, 1'b0);

    // Failure wins over success; LOST is terminal
    wait_tick(20, used);
    check_eq("pre_fail_period", used, 15);
    finish_move(1'b1, 1'b0, 1'b0);
    place_apple();
    wait_tick(20, used);
    check_eq("fail_period", used, 15);
    finish_move(1'b0, 1'b1, 1'b1);
    check_eq("fail_lost", o_state, 5);
    check_eq("fail_score_kept", o_score, 1);
    check_eq("fail_not_running", o_running, 0);
    quiet_vsyncs(20, 19, ticks);
    check_eq("lost_no_tick", ticks, 0);
    check_eq("lost_terminal", o_state, 5);
    restart_game();

    // Success alone gives WON
    start_game();
    wait_tick(20, used);
    check_eq("won_period", used, 15);
    finish_move(1'b0, 1'b0, 1'b1);
    check_eq("won_state", o_state, 6);
    restart_game();

    // Watchdog: error and LOST exactly 255 cycles after the tick
    start_game();
    wait_tick(20, used);
    check_eq("wd_period", used, 15);
    repeat (254) step();
    check_eq("wd_not_yet_state", o_state, 2);
    check_eq("wd_not_yet_error", o_error, 0);
    step();
    check_eq("wd_error", o_error, 1);
    check_eq("wd_lost", o_state, 5);
    i_tick_done = 1'b1;
    step();
    i_tick_done = 1'b0;
    check_eq("wd_done_ignored", o_state, 5);
    check_eq("wd_error_sticky", o_error, 1);
    restart_game();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
